multicycle_control: RTL and testbench

//  Multi-cycle sequencer for the RV32 datapath: replaces the one-shot opcode decode with an FSM.

---
 rtl/multicycle_control.sv | 171 +++++++++++++++++
 tb/tb_multicycle_control.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle RV32 control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT over one shared memory port.
// Optional perf counters (CycleCount, InstrRetired) are enabled by defining MULTICYCLE_PERF_CNT_EN.
module multicycle_control #(
    parameter int unsigned CNT_WIDTH    = 32,
    parameter bit          ILLEGAL_HALT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Run,
    input  logic [6:0] Opcode,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       InstrRead,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       ALUSrc,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       PCWrite,
    output logic       PCSrc,
    output logic [1:0] ALUOp,
    output logic       Illegal,
    output logic [2:0] State
`ifdef MULTICYCLE_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] CycleCount,
    output logic [CNT_WIDTH-1:0] InstrRetired
`endif
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    state_t     state, state_next;
    logic [6:0] op_q;
    logic [6:0] op_cur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            op_q  <= '0;
        end else begin
            state <= state_next;
            if (state == DECODE) op_q <= Opcode;
        end
    end

    // DECODE sees the raw opcode; every later state uses only the copy captured there.
    assign op_cur = (state == DECODE) ? Opcode : op_q;

    always_comb begin
        state_next = state;
        InstrRead  = 1'b0;
        IRWrite    = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        ALUSrc     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        PCWrite    = 1'b0;
        PCSrc      = 1'b0;
        ALUOp      = 2'b00;
        Illegal    = 1'b0;
        State      = state;
        case (state)
            FETCH: begin
                InstrRead = Run;
                if (Run && MemReady) begin
                    IRWrite    = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                case (op_cur)
                    OP_R, OP_LW, OP_SW, OP_BEQ: state_next = EXEC;
                    default: begin
                        Illegal = 1'b1;
                        if (ILLEGAL_HALT) begin
                            state_next = HALT;
                        end else begin
                            PCWrite    = 1'b1;
                            state_next = FETCH;
                        end
                    end
                endcase
            end
            EXEC: begin
                case (op_cur)
                    OP_R: begin
                        ALUOp      = 2'b10;
                        state_next = WB;
                    end
                    OP_LW, OP_SW: begin
                        ALUSrc     = 1'b1;
                        state_next = MEM;
                    end
                    OP_BEQ: begin
                        ALUOp      = 2'b01;
                        PCWrite    = 1'b1;
                        PCSrc      = Zero;
                        state_next = FETCH;
                    end
                    default: state_next = FETCH;
                endcase
            end
            MEM: begin
                ALUSrc = 1'b1;
                if (op_cur == OP_SW) begin
                    MemWrite = 1'b1;
                    if (MemReady) begin
                        PCWrite    = 1'b1;
                        state_next = FETCH;
                    end
                end else begin
                    MemRead = 1'b1;
                    if (MemReady) state_next = WB;
                end
            end
            WB: begin
                RegWrite   = 1'b1;
                MemtoReg   = (op_cur == OP_LW);
                PCWrite    = 1'b1;
                state_next = FETCH;
            end
            HALT: state_next = HALT;
            default: state_next = FETCH;
        endcase
        // Outputs are forced low combinationally so reset silences them regardless of inputs.
        if (!rst_n) begin
            InstrRead = 1'b0;
            IRWrite   = 1'b0;
            MemRead   = 1'b0;
            MemWrite  = 1'b0;
            ALUSrc    = 1'b0;
            MemtoReg  = 1'b0;
            RegWrite  = 1'b0;
            PCWrite   = 1'b0;
            PCSrc     = 1'b0;
            ALUOp     = 2'b00;
            Illegal   = 1'b0;
            State     = 3'd0;
        end
    end

`ifdef MULTICYCLE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            CycleCount   <= '0;
            InstrRetired <= '0;
        end else begin
            if (state != HALT) CycleCount <= CycleCount + 1'b1;
            if (PCWrite) InstrRetired <= InstrRetired + 1'b1;
        end
    end
`else
    // Counters absent in this build.
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: two instances (ILLEGAL_HALT 0 and 1) checked every cycle
// against a sequence-table model, plus directed latency/pulse-count expectations.
module tb_multicycle_control;

    localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_ILL = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       Run = 1'b0;
    logic [6:0] Opcode = '0;
    logic       Zero = 1'b0;
    logic       MemReady = 1'b0;

    logic [1:0] ir, irw, mrd, mwr, asrc, m2r, rw, pcw, pcs, ill;
    logic [1:0] aop [2];
    logic [2:0] st  [2];
`ifdef MULTICYCLE_PERF_CNT_EN
    logic [31:0] cyc [2];
    logic [31:0] ret [2];
`endif

    int checks = 0;
    int errors = 0;

    int m_pos  [2];
    int m_kind [2];
    bit m_halt [2];
    logic [31:0] m_cyc [2];
    logic [31:0] m_ret [2];

    int c_ir = 0, c_irw = 0, c_mrd = 0, c_mwr = 0, c_rw = 0, c_pcw = 0, c_ill = 0, c_st5 = 0;

    always #5 clk = ~clk;

    multicycle_control #(.CNT_WIDTH(32), .ILLEGAL_HALT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .Run(Run), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .InstrRead(ir[0]), .IRWrite(irw[0]), .MemRead(mrd[0]), .MemWrite(mwr[0]),
        .ALUSrc(asrc[0]), .MemtoReg(m2r[0]), .RegWrite(rw[0]), .PCWrite(pcw[0]),
        .PCSrc(pcs[0]), .ALUOp(aop[0]), .Illegal(ill[0]), .State(st[0])
`ifdef MULTICYCLE_PERF_CNT_EN
        , .CycleCount(cyc[0]), .InstrRetired(ret[0])
`endif
    );

    multicycle_control #(.CNT_WIDTH(32), .ILLEGAL_HALT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .Run(Run), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .InstrRead(ir[1]), .IRWrite(irw[1]), .MemRead(mrd[1]), .MemWrite(mwr[1]),
        .ALUSrc(asrc[1]), .MemtoReg(m2r[1]), .RegWrite(rw[1]), .PCWrite(pcw[1]),
        .PCSrc(pcs[1]), .ALUOp(aop[1]), .Illegal(ill[1]), .State(st[1])
`ifdef MULTICYCLE_PERF_CNT_EN
        , .CycleCount(cyc[1]), .InstrRetired(ret[1])
`endif
    );

    function automatic int classify(input logic [6:0] op);
        case (op)
            7'b0110011: return K_R;
            7'b0000011: return K_LW;
            7'b0100011: return K_SW;
            7'b1100011: return K_BEQ;
            default:    return K_ILL;
        endcase
    endfunction

    // Stage list per instruction kind: F,D,E then kind-specific tail.
    function automatic int seq_len(input int k);
        case (k)
            K_R:     return 4;
            K_LW:    return 5;
            K_SW:    return 4;
            K_BEQ:   return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int stage_of(input int k, input int p, input bit h);
        if (h) return 5;
        case (p)
            0: return 0;
            1: return 1;
            2: return 2;
            3: return (k == K_R) ? 4 : 3;
            default: return 4;
        endcase
    endfunction

    // Vector: ir,irw,mrd,mwr,asrc,m2r,rw,pcw,pcs,aop[1:0],ill,st[2:0]
    function automatic logic [14:0] dut_vec(input int i);
        return {ir[i], irw[i], mrd[i], mwr[i], asrc[i], m2r[i], rw[i], pcw[i], pcs[i],
                aop[i], ill[i], st[i]};
    endfunction

    function automatic logic [14:0] model_out(input int i);
        logic [14:0] v;
        int s;
        v = '0;
        if (!rst_n) return v;
        s = stage_of(m_kind[i], m_pos[i], m_halt[i]);
        v[2:0] = s[2:0];
        case (s)
            0: begin
                v[14] = Run;
                v[13] = Run & MemReady;
            end
            1: if (classify(Opcode) == K_ILL) begin
                v[3] = 1'b1;
                if (i == 0) v[7] = 1'b1;
            end
            2: case (m_kind[i])
                K_R:  v[5:4] = 2'b10;
                K_LW, K_SW: v[10] = 1'b1;
                K_BEQ: begin
                    v[5:4] = 2'b01;
                    v[7]   = 1'b1;
                    v[6]   = Zero;
                end
                default: ;
            endcase
            3: begin
                v[10] = 1'b1;
                if (m_kind[i] == K_LW) v[12] = 1'b1;
                if (m_kind[i] == K_SW) begin
                    v[11] = 1'b1;
                    v[7]  = MemReady;
                end
            end
            4: begin
                v[8] = 1'b1;
                v[9] = (m_kind[i] == K_LW);
                v[7] = 1'b1;
            end
            default: ;
        endcase
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            int p, k, s;
            bit h;
            if (!rst_n) begin
                m_pos[i]  <= 0;
                m_kind[i] <= K_R;
                m_halt[i] <= 1'b0;
                m_cyc[i]  <= '0;
                m_ret[i]  <= '0;
            end else begin
                p = m_pos[i];
                k = m_kind[i];
                h = m_halt[i];
                s = stage_of(k, p, h);
                if (!h) m_cyc[i] <= m_cyc[i] + 1;
                if (model_out(i)[7]) m_ret[i] <= m_ret[i] + 1;
                if (h) begin
                end else if (s == 0) begin
                    if (Run && MemReady) p = 1;
                end else if (s == 1) begin
                    k = classify(Opcode);
                    if (k == K_ILL) begin
                        if (i == 1) h = 1'b1;
                        else p = 0;
                    end else begin
                        p = 2;
                    end
                end else if (s == 3 && !MemReady) begin
                end else if (p == seq_len(k) - 1) begin
                    p = 0;
                end else begin
                    p = p + 1;
                end
                m_pos[i]  <= p;
                m_kind[i] <= k;
                m_halt[i] <= h;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dut_vec(i) !== model_out(i)) begin
                errors++;
                $display("FAIL outputs dut%0d t=%0t: got %b expected %b", i, $time,
                         dut_vec(i), model_out(i));
            end
`ifdef MULTICYCLE_PERF_CNT_EN
            checks++;
            if (cyc[i] !== m_cyc[i] || ret[i] !== m_ret[i]) begin
                errors++;
                $display("FAIL counters dut%0d: got cyc=%0d ret=%0d expected cyc=%0d ret=%0d",
                         i, cyc[i], ret[i], m_cyc[i], m_ret[i]);
            end
`endif
        end
        c_ir  += int'(ir[0]);
        c_irw += int'(irw[0]);
        c_mrd += int'(mrd[0]);
        c_mwr += int'(mwr[0]);
        c_rw  += int'(rw[0]);
        c_pcw += int'(pcw[0]);
        c_ill += int'(ill[0]);
        c_st5 += int'(st[1] == 3'd5);
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Runs one instruction on dut0; MemReady low for fs FETCH cycles and ms MEM cycles.
    // Opcode is inverted after DECODE so any use of the raw opcode shows up.
    task automatic run_instr(input logic [6:0] op, input int fs, input int ms, input logic z,
                             output int cycles, output int seq_code, output int pcsrc_at);
        Run = 1'b1;
        Zero = z;
        cycles = 0;
        seq_code = 0;
        pcsrc_at = -1;
        for (int c = 0; c < 60; c++) begin
            MemReady = (c < fs) ? 1'b0 : ((c >= fs + 3 && c < fs + 3 + ms) ? 1'b0 : 1'b1);
            Opcode   = (c <= fs + 1) ? op : ~op;
            @(negedge clk);
            seq_code = seq_code * 8 + int'(st[0]);
            if (pcw[0] === 1'b1 && cycles == 0) begin
                cycles = c + 1;
                pcsrc_at = int'(pcs[0]);
            end
            @(posedge clk);
            #1;
            if (cycles != 0) break;
        end
        if (cycles == 0) begin
            errors++;
            $display("FAIL timeout: no PCWrite for opcode %b", op);
        end
    endtask

    initial begin
        int cy, sq, ps;
        int s_ir, s_irw, s_mrd, s_mwr, s_rw, s_pcw, s_ill, s_st5;
        int found;

        // Reset with active inputs: outputs must stay low.
        Run = 1'b1;
        MemReady = 1'b1;
        Opcode = 7'b0110011;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", int'(st[0]), 0);
        check("reset_instr_read", int'(ir[0]), 0);
        Run = 1'b0;
        rst_n = 1'b1;

        // Run=0 idles in FETCH with no request.
        s_ir = c_ir;
        repeat (3) @(posedge clk);
        #1;
        check("idle_instr_read", c_ir - s_ir, 0);
        check("idle_state", int'(st[0]), 0);

        // T1 R-type
        s_rw = c_rw;
        run_instr(7'b0110011, 0, 0, 1'b0, cy, sq, ps);
        check("rtype_cycles", cy, 4);
        check("rtype_states", sq, 84);
        check("rtype_regwrite", c_rw - s_rw, 1);
        check("rtype_back_fetch", int'(st[0]), 0);

        // T2 lw with 2 wait cycles in MEM
        s_mrd = c_mrd; s_rw = c_rw;
        run_instr(7'b0000011, 0, 2, 1'b0, cy, sq, ps);
        check("lw_cycles", cy, 7);
        check("lw_memread_cycles", c_mrd - s_mrd, 3);
        check("lw_regwrite", c_rw - s_rw, 1);

        // T3 beq taken / not taken
        s_rw = c_rw; s_mwr = c_mwr;
        run_instr(7'b1100011, 0, 0, 1'b1, cy, sq, ps);
        check("beq_taken_cycles", cy, 3);
        check("beq_taken_pcsrc", ps, 1);
        run_instr(7'b1100011, 0, 0, 1'b0, cy, sq, ps);
        check("beq_not_taken_cycles", cy, 3);
        check("beq_not_taken_pcsrc", ps, 0);
        check("beq_no_writes", (c_rw - s_rw) + (c_mwr - s_mwr), 0);

        // T4 sw with 4-cycle fetch stall
        s_ir = c_ir; s_irw = c_irw; s_mwr = c_mwr; s_rw = c_rw;
        run_instr(7'b0100011, 4, 0, 1'b0, cy, sq, ps);
        check("sw_cycles", cy, 8);
        check("sw_instr_read_cycles", c_ir - s_ir, 5);
        check("sw_irwrite", c_irw - s_irw, 1);
        check("sw_memwrite", c_mwr - s_mwr, 1);
        check("sw_no_regwrite", c_rw - s_rw, 0);

        // T5 illegal: dut0 skips, dut1 parks in HALT
        s_ill = c_ill;
        run_instr(7'b1111111, 0, 0, 1'b0, cy, sq, ps);
        check("illegal_cycles", cy, 2);
        check("illegal_pulse", c_ill - s_ill, 1);
        check("halt_state", int'(st[1]), 5);
        s_st5 = c_st5;
        repeat (10) @(posedge clk);
        #1;
        check("halt_held_cycles", c_st5 - s_st5, 10);
        check("halt_outputs", int'(dut_vec(1)), 5);

        // T6 reset while sw waits in MEM
        Run = 1'b1;
        Opcode = 7'b0100011;
        found = 0;
        for (int c = 0; c < 10; c++) begin
            MemReady = (c < 3) ? 1'b1 : 1'b0;
            @(negedge clk);
            if (mwr[0] === 1'b1) begin
                found = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("mem_write_reached", found, 1);
        @(posedge clk);
        #1;
        s_pcw = c_pcw;
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_mid_mem_outputs", int'(dut_vec(0)), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("after_reset_state", int'(st[0]), 0);
        check("reset_no_pcwrite", c_pcw - s_pcw, 0);
`ifdef MULTICYCLE_PERF_CNT_EN
        check("reset_cycle_count", int'(cyc[0]), 0);
        check("reset_instr_retired", int'(ret[0]), 0);
`endif
        @(posedge clk);
        #1;

        // Normal operation resumes after reset.
        run_instr(7'b0110011, 0, 0, 1'b0, cy, sq, ps);
        check("post_reset_rtype_cycles", cy, 4);
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
